// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: register map, ctrl fields,
// ownership state encoding and the fixed debug-mode display settings.
package seg_pkg;

  localparam logic [1:0] REG_NUM  = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;

  localparam int unsigned CTRL_SW_LSB     = 0;
  localparam int unsigned CTRL_DP_LSB     = 4;
  localparam int unsigned CTRL_FREEZE_BIT = 8;

  // Only sw_mode[1:0], dp[7:4] and freeze[8] are implemented in ctrl.
  localparam logic [31:0] CTRL_MASK  = 32'h0000_01F3;
  localparam logic [31:0] CTRL_RESET = 32'h0000_0001;

  typedef enum logic {
    ST_CPU = 1'b0,
    ST_DBG = 1'b1
  } own_state_e;

  localparam logic [1:0] DBG_SW = 2'b01;
  localparam logic [3:0] DBG_DP = 4'b1111;

  function automatic logic [31:0] status_word(input logic active, input logic [1:0] scan);
    return {29'b0, active, scan};
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Free-running prescaler and 2-bit digit scan counter; the scan index steps on
// each prescaler wrap unless frozen.
module seg_scan_timer #(
  parameter int unsigned DIV_W = 17
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       i_freeze,
  output logic       o_wrap_c,
  output logic [1:0] o_scan
);

  logic [DIV_W-1:0] r_presc;
  logic [1:0]       r_scan;
  logic             w_wrap;

  assign w_wrap = (r_presc == {DIV_W{1'b1}});

  always_ff @(posedge clk) begin
    if (clr) begin
      r_presc <= '0;
      r_scan  <= 2'd0;
    end else begin
      r_presc <= r_presc + DIV_W'(1);
      if (w_wrap && !i_freeze) begin
        r_scan <= r_scan + 2'd1;
      end
    end
  end

  assign o_wrap_c = w_wrap;
  assign o_scan   = r_scan;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Bus register file, CPU/debug display ownership arbiter and output mux in front
// of the shared 4-digit 7-segment driver.
module seg_scan_ctrl #(
  parameter int unsigned       DIV_W       = 17,
  parameter int unsigned       HOLD_W      = 24,
  parameter logic [HOLD_W-1:0] HOLD_CYCLES = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  input  logic        dbg_req,
  input  logic [31:0] dbg_num,
  output logic        dbg_ack,
  output logic        dbg_active,
  output logic [31:0] disp_num,
  output logic [1:0]  SW,
  output logic [1:0]  Scanning,
  output logic [3:0]  dpdot
);

  import seg_pkg::*;

  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_CYCLES - HOLD_W'(1);

  logic [31:0]       r_num;
  logic [31:0]       r_ctrl;
  logic [31:0]       r_rd;
  logic [31:0]       r_latch;
  logic [HOLD_W-1:0] r_hold;
  logic              r_ack;
  own_state_e        r_state;

  logic [31:0]       w_rd_mux;
  logic [1:0]        w_scan;
  logic              w_dbg;
  logic              w_unused_wrap;

  // Wrap strobe is exposed by the timer for tick-aligned features; not needed here.
  seg_scan_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .clk      (clk),
    .clr      (clr),
    .i_freeze (r_ctrl[CTRL_FREEZE_BIT]),
    .o_wrap_c (w_unused_wrap),
    .o_scan   (w_scan)
  );

  assign w_dbg = (r_state == ST_DBG);

  always_comb begin
    w_rd_mux = 32'd0;
    case (rd_addr)
      REG_NUM:  w_rd_mux = r_num;
      REG_CTRL: w_rd_mux = r_ctrl;
      REG_STAT: w_rd_mux = status_word(w_dbg, w_scan);
      default:  w_rd_mux = 32'd0;
    endcase
  end

  // CPU shadow registers and registered read port; writes land even while debug owns the display.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_num  <= 32'd0;
      r_ctrl <= CTRL_RESET;
      r_rd   <= 32'd0;
    end else begin
      r_rd <= w_rd_mux;
      if (wr_en) begin
        case (wr_addr)
          REG_NUM:  r_num  <= wr_data;
          REG_CTRL: r_ctrl <= wr_data & CTRL_MASK;
          default:  ;
        endcase
      end
    end
  end

  // Ownership FSM: every sampled request (re)arms the hold and acks the next cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_CPU;
      r_hold  <= '0;
      r_latch <= 32'd0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= dbg_req;
      case (r_state)
        ST_CPU: begin
          if (dbg_req) begin
            r_state <= ST_DBG;
            r_latch <= dbg_num;
            r_hold  <= HOLD_RELOAD;
          end
        end
        ST_DBG: begin
          if (dbg_req) begin
            r_latch <= dbg_num;
            r_hold  <= HOLD_RELOAD;
          end else if (r_hold != '0) begin
            r_hold <= r_hold - HOLD_W'(1);
          end else begin
            r_state <= ST_CPU;
          end
        end
        default: r_state <= ST_CPU;
      endcase
    end
  end

  assign disp_num   = w_dbg ? r_latch : r_num;
  assign SW         = w_dbg ? DBG_SW  : r_ctrl[CTRL_SW_LSB +: 2];
  assign dpdot      = w_dbg ? DBG_DP  : r_ctrl[CTRL_DP_LSB +: 4];
  assign Scanning   = w_scan;
  assign dbg_active = w_dbg;
  assign dbg_ack    = r_ack;
  assign rd_data    = r_rd;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (DIV_W=2, HOLD_CYCLES=5): the driver queues
// expected output values tagged with a cycle number; a negedge monitor checks them.
module tb_seg_scan_ctrl;

  typedef enum int {S_DISP, S_SW, S_DP, S_SCAN, S_ACT, S_ACK, S_RD} sel_e;

  typedef struct {
    int          cyc;
    sel_e        sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk     = 1'b0;
  logic        clr     = 1'b1;
  logic        wr_en   = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic [1:0]  rd_addr = 2'd0;
  logic        dbg_req = 1'b0;
  logic [31:0] dbg_num = 32'd0;
  logic [31:0] rd_data;
  logic        dbg_ack;
  logic        dbg_active;
  logic [31:0] disp_num;
  logic [1:0]  SW;
  logic [1:0]  Scanning;
  logic [3:0]  dpdot;

  exp_t sb[$];
  int   n_pos    = 0;
  int   base     = 0;
  int   checks   = 0;
  int   failures = 0;

  seg_scan_ctrl #(
    .DIV_W       (2),
    .HOLD_W      (24),
    .HOLD_CYCLES (24'd5)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .dbg_req    (dbg_req),
    .dbg_num    (dbg_num),
    .dbg_ack    (dbg_ack),
    .dbg_active (dbg_active),
    .disp_num   (disp_num),
    .SW         (SW),
    .Scanning   (Scanning),
    .dpdot      (dpdot)
  );

  always #5 clk = ~clk;

  always @(posedge clk) n_pos <= n_pos + 1;

  function automatic logic [31:0] pick(input sel_e s);
    case (s)
      S_DISP:  return disp_num;
      S_SW:    return {30'd0, SW};
      S_DP:    return {28'd0, dpdot};
      S_SCAN:  return {30'd0, Scanning};
      S_ACT:   return {31'd0, dbg_active};
      S_ACK:   return {31'd0, dbg_ack};
      default: return rd_data;
    endcase
  endfunction

  // Expect output 'sel' to equal 'v' at the negedge after posedge number base+t.
  function automatic void ex(input int t, input sel_e s, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = base + t;
    e.sel  = s;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endfunction

  task automatic go(input int t);
    while (n_pos - base < t) @(negedge clk);
  endtask

  // Monitor: compare every queued expectation that falls due this cycle.
  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc == n_pos) begin
        act = pick(sb[i].sel);
        checks++;
        if (act !== sb[i].val) begin
          failures++;
          $display("FAIL %s t=%0d got=%h exp=%h", sb[i].name, sb[i].cyc - base, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    @(negedge clk);
    base = n_pos + 1;
    ex(0, S_DISP, 32'd0, "rst_disp");
    ex(0, S_SW,   32'd1, "rst_sw");
    ex(0, S_DP,   32'd0, "rst_dp");
    ex(0, S_SCAN, 32'd0, "rst_scan");
    ex(0, S_ACT,  32'd0, "rst_active");
    ex(0, S_ACK,  32'd0, "rst_ack");
    ex(0, S_RD,   32'd0, "rst_rd");
    go(0);
    clr = 1'b0;
    ex(3,  S_SCAN, 32'd0, "scan_t3");
    ex(4,  S_SCAN, 32'd1, "scan_t4");
    ex(7,  S_SCAN, 32'd1, "scan_t7");
    ex(8,  S_SCAN, 32'd2, "scan_t8");
    ex(12, S_SCAN, 32'd3, "scan_t12");
    ex(16, S_SCAN, 32'd0, "scan_wrap_t16");

    go(16);
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'h1234_ABCD;
    ex(17, S_DISP, 32'h1234_ABCD, "wr_num_disp");
    go(17);
    wr_addr = 2'd1; wr_data = 32'h0000_00F3;
    ex(18, S_DISP, 32'h1234_ABCD, "ctrl_disp");
    ex(18, S_SW,   32'd3,         "ctrl_sw");
    ex(18, S_DP,   32'hF,         "ctrl_dp");
    go(18);
    wr_en = 1'b0; rd_addr = 2'd1;
    ex(19, S_RD, 32'h0000_00F3, "rd_ctrl");

    go(24);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'h0000_01F3;
    ex(28, S_SCAN, 32'd2, "freeze_t28");
    ex(36, S_SCAN, 32'd2, "freeze_t36");
    ex(44, S_SCAN, 32'd2, "freeze_t44");
    go(25);
    wr_en = 1'b0;
    go(44);
    wr_en = 1'b1; wr_data = 32'hABCD_00F3;
    ex(47, S_SCAN, 32'd2, "unfreeze_t47");
    ex(48, S_SCAN, 32'd3, "unfreeze_t48");
    go(45);
    wr_en = 1'b0; rd_addr = 2'd1;
    ex(46, S_RD, 32'h0000_00F3, "rd_ctrl_masked");
    go(46);
    rd_addr = 2'd2;
    ex(47, S_RD, 32'd2, "rd_stat_scan2");
    go(48);
    ex(49, S_RD, 32'd3, "rd_stat_scan3");
    ex(50, S_ACT, 32'd0, "pre_dbg_active");
    ex(50, S_ACK, 32'd0, "pre_dbg_ack");

    go(50);
    dbg_req = 1'b1; dbg_num = 32'hDEAD_BEEF;
    ex(51, S_ACK,  32'd1,         "dbg_ack_pulse");
    ex(52, S_ACK,  32'd0,         "dbg_ack_low");
    ex(51, S_ACT,  32'd1,         "dbg_act_first");
    ex(55, S_ACT,  32'd1,         "dbg_act_last");
    ex(56, S_ACT,  32'd0,         "dbg_act_end");
    ex(51, S_DISP, 32'hDEAD_BEEF, "dbg_disp");
    ex(51, S_SW,   32'd1,         "dbg_sw");
    ex(51, S_DP,   32'hF,         "dbg_dp");
    ex(55, S_DISP, 32'hDEAD_BEEF, "dbg_disp_held");
    ex(56, S_DISP, 32'h1234_ABCD, "restore_disp");
    ex(56, S_SW,   32'd3,         "restore_sw");
    ex(56, S_DP,   32'hF,         "restore_dp");
    go(51);
    dbg_req = 1'b0; dbg_num = 32'd0;
    go(52);
    rd_addr = 2'd2;
    ex(53, S_RD, 32'd4, "rd_stat_dbg");

    go(60);
    dbg_req = 1'b1; dbg_num = 32'hDEAD_BEEF;
    ex(61, S_ACK,  32'd1,         "dbg2_ack");
    ex(61, S_DISP, 32'hDEAD_BEEF, "dbg2_disp");
    go(61);
    dbg_req = 1'b0; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'h5555_5555;
    ex(62, S_DISP, 32'hDEAD_BEEF, "shadow_wr_hidden");
    ex(62, S_ACK,  32'd0,         "dbg2_ack_low");
    go(62);
    wr_en = 1'b0;
    go(63);
    dbg_req = 1'b1; dbg_num = 32'h0BAD_F00D;
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'h0000_0021;
    ex(64, S_ACK,  32'd1,         "reack");
    ex(64, S_DISP, 32'h0BAD_F00D, "reack_latch");
    ex(65, S_ACK,  32'd0,         "reack_low");
    ex(66, S_ACT,  32'd1,         "extend_t66");
    ex(68, S_ACT,  32'd1,         "extend_t68");
    ex(68, S_DISP, 32'h0BAD_F00D, "extend_disp");
    ex(69, S_ACT,  32'd0,         "extend_end");
    ex(69, S_DISP, 32'h5555_5555, "shadow_visible");
    ex(69, S_SW,   32'd1,         "shadow_sw");
    ex(69, S_DP,   32'd2,         "shadow_dp");
    go(64);
    dbg_req = 1'b0; wr_en = 1'b0; dbg_num = 32'd0;

    go(75);
    dbg_req = 1'b1; dbg_num = 32'hCAFE_F00D; rd_addr = 2'd0;
    go(76);
    dbg_req = 1'b0;
    ex(77, S_ACT,  32'd1,         "pre_clr_active");
    ex(77, S_RD,   32'h5555_5555, "pre_clr_rd");
    ex(77, S_SCAN, 32'd2,         "pre_clr_scan");
    go(77);
    clr = 1'b1;
    ex(78, S_ACT,  32'd0, "clr_active");
    ex(78, S_DISP, 32'd0, "clr_disp");
    ex(78, S_SCAN, 32'd0, "clr_scan");
    ex(78, S_RD,   32'd0, "clr_rd");
    ex(78, S_SW,   32'd1, "clr_sw");
    ex(78, S_DP,   32'd0, "clr_dp");
    ex(78, S_ACK,  32'd0, "clr_ack");
    go(78);
    clr = 1'b0;
    ex(81, S_SCAN, 32'd0, "post_clr_t81");
    ex(82, S_SCAN, 32'd1, "post_clr_t82");
    go(84);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Sequences and shares the 4-digit multiplexed 7-segment display driver.
- Generates the digit scan index (`Scanning`) from a clock prescaler.
- Holds CPU-programmed display number and control bits in bus registers.
- Arbitrates display ownership between the CPU bus and a debug requester. Debug has priority, with a timed hold.
- Outputs (`disp_num`, `SW`, `Scanning`, `dpdot`) connect directly to the existing 7-segment driver inputs of the same names.

Parameters:
- DIV_W, 17, prescaler width; `Scanning` advances every 2^DIV_W clocks.
- HOLD_W, 24, width of the debug hold counter.
- HOLD_CYCLES, 24'd10_000_000, number of cycles `dbg_active` stays high per accepted debug request (must be ≥1).

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous active-high reset
- wr_en  in  1  CPU register write strobe
- wr_addr  in  2  write register index
- wr_data  in  32  write data
- rd_addr  in  2  read register index
- rd_data  out  32  read data, registered, 1-cycle latency
- dbg_req  in  1  debug display request (level, sampled each cycle)
- dbg_num  in  32  debug display value
- dbg_ack  out  1  one-cycle pulse: request accepted
- dbg_active  out  1  debug currently owns the display
- disp_num  out  32  number to driver
- SW  out  2  driver mode: [0]=hex decode, [1]=upper half select
- Scanning  out  2  current digit index
- dpdot  out  4  decimal-point enables

Behaviour:
- Reset (clr=1 at a clk edge, highest priority over everything):
  - cpu_num=0, ctrl=0x0000_0001, prescaler=0, Scanning=0, dbg_active=0, hold_cnt=0, dbg_ack=0, dbg_latch=0, rd_data=0.
  - Resulting outputs: disp_num=0, SW=2'b01, dpdot=0.
- Register map:
  - 0: cpu_num (RW).
  - 1: ctrl (RW, only bits [1:0] sw_mode, [7:4] dp, [8] freeze are stored; other bits read 0).
  - 2: status (RO) = {29'b0, dbg_active, Scanning}.
  - 3: reads 0.
  - Writes to 2 and 3 are ignored.
- CPU writes:
  - Take effect at the edge where wr_en=1.
  - Writes are accepted even while dbg_active=1; they update the shadow registers only and become visible when debug ends.
- Reads: rd_data at edge N+1 reflects register state after edge N (read of a same-cycle write returns the old value).
- Prescaler:
  - Free-running DIV_W-bit counter, wraps at all-ones.
  - At the edge where it wraps and freeze=0, Scanning increments modulo 4 (3→0).
  - With freeze=1 the prescaler keeps counting but Scanning holds.
  - Clearing freeze resumes advancing at the next wrap.
- Ownership FSM, two states: CPU and DEBUG.
  - CPU: dbg_req=1 at an edge → DEBUG.
    - dbg_latch←dbg_num, hold_cnt←HOLD_CYCLES-1, dbg_ack=1 for that one following cycle.
  - DEBUG, dbg_req=1 → re-accept: reload hold_cnt and dbg_latch, pulse dbg_ack again. Holding dbg_req high keeps DEBUG indefinitely, acking every cycle.
  - DEBUG, dbg_req=0, hold_cnt≠0 → decrement.
  - DEBUG, dbg_req=0, hold_cnt=0 → CPU.
  - A single one-cycle request therefore gives dbg_active=1 for exactly HOLD_CYCLES cycles.
- Output mux (combinational from registers, no extra latency):
  - CPU state: disp_num=cpu_num, SW=ctrl[1:0], dpdot=ctrl[7:4].
  - DEBUG state: disp_num=dbg_latch, SW=2'b01, dpdot=4'b1111.
- Simultaneous dbg_req and wr_en: both are honoured; the write goes to the shadow registers.
- Reset mid-debug: immediately returns to CPU with all registers at reset values.

Decomposition:
- Shared package seg_pkg:
  - Register index constants (REG_NUM=0, REG_CTRL=1, REG_STAT=2).
  - Ctrl bit-field positions.
  - Ownership state encoding (ST_CPU=0, ST_DBG=1).
  - Debug-mode constants (DBG_SW=2'b01, DBG_DP=4'b1111).
- One natural sub-module: seg_scan_timer. It holds the prescaler plus the Scanning counter, with freeze input and wrap output.
- Register file, FSM and output mux remain in the top.

Test Plan (DIV_W=2, HOLD_CYCLES=5):
- Reset → disp_num=0, SW=01, dpdot=0, Scanning=0. Free run 16 cycles → Scanning sequence 0,1,2,3,0, one step every 4 cycles.
- Write reg0=0x1234_ABCD, reg1=0x0000_00F3 → disp_num=0x1234ABCD, SW=11, dpdot=F the same cycle. Read reg1 → rd_data=0x000000F3 one cycle later.
- Write reg1 bit8=1 while Scanning=2 → Scanning stays 2 for 20 cycles. Clear bit8 → advances to 3 at the next wrap.
- One-cycle dbg_req with dbg_num=0xDEAD_BEEF → dbg_ack single pulse, dbg_active high exactly 5 cycles, disp_num=0xDEADBEEF, SW=01, dpdot=F, then CPU values restored.
- During debug, write reg0=0x5555_5555 → disp_num stays 0xDEADBEEF. After the hold ends → 0x55555555. A second dbg_req at hold cycle 3 → extends dbg_active by 5 cycles from the re-ack.
- clr asserted on hold cycle 2 → next cycle dbg_active=0, disp_num=0, Scanning=0, rd_data=0.
